// File: rtl/cmd_seq_proc.sv
// cmd_seq_proc: command sequencer for the line-following robot.
// A packed command word is captured from the UART wrapper and consumed two
// bits at a time, one step per line-loss event. Each step is a stop, a veer
// right, a veer left or a two-phase U-turn. A bumper hit overrides any active
// step: motion halts, the buzzer sounds, and motion resumes only after both
// bumpers have been released for a debounce interval. The interrupted step
// is not consumed, so it is decoded again on the next line loss.

module cmd_seq_proc #(
    parameter int          CMD_W     = 16,
    parameter logic [15:0] VEER_MAG  = 16'h340,
    parameter logic [15:0] REV1_MAG  = 16'h1E0,
    parameter logic [15:0] REV2_MAG  = 16'h380,
    parameter int          REV1_CYC  = 1441792,
    parameter int          REV2_CYC  = 65011712,
    parameter int          DBNC_CYC  = 4194304,
    parameter int          BUZZ_HALF = 25000,
    parameter int          TMR_W     = 27,
    localparam int         N_STEPS   = CMD_W / 2,
    localparam int         SL_W      = $clog2(N_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_rdy,
    output logic             clr_cmd_rdy,
    input  logic             line_present,
    input  logic             BMPL_n,
    input  logic             BMPR_n,
    output logic             go,
    output logic [15:0]      err_opn_lp,
    output logic             buzz,
    output logic [SL_W-1:0]  steps_left,
    output logic             cmd_done
);

    // Sequencer states
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FOLLOW = 3'd1;
    localparam logic [2:0] VEER   = 3'd2;
    localparam logic [2:0] REV1   = 3'd3;
    localparam logic [2:0] REV2   = 3'd4;
    localparam logic [2:0] REACQ  = 3'd5;
    localparam logic [2:0] BUMP   = 3'd6;
    localparam logic [2:0] DBNC   = 3'd7;

    // Step codes held in the low two bits of the shift register
    localparam logic [1:0] CODE_STOP  = 2'b00;
    localparam logic [1:0] CODE_RIGHT = 2'b01;
    localparam logic [1:0] CODE_UTURN = 2'b11;

    // Terminal counts: a phase expires on its last cycle, so it lasts CYC cycles
    localparam logic [TMR_W-1:0] REV1_LAST = TMR_W'(REV1_CYC - 1);
    localparam logic [TMR_W-1:0] REV2_LAST = TMR_W'(REV2_CYC - 1);
    localparam logic [TMR_W-1:0] DBNC_LAST = TMR_W'(DBNC_CYC - 1);

    localparam int               BZ_W    = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [BZ_W-1:0]  BZ_LAST = BZ_W'(BUZZ_HALF - 1);

    localparam logic [SL_W-1:0]  SL_FULL = SL_W'(N_STEPS);
    localparam logic [SL_W-1:0]  SL_ONE  = SL_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [BZ_W-1:0]  BZ_ONE  = BZ_W'(1);

    // Two's complement negatives of the steering magnitudes
    localparam logic [15:0] VEER_NEG = ~VEER_MAG + 16'd1;
    localparam logic [15:0] REV1_NEG = ~REV1_MAG + 16'd1;
    localparam logic [15:0] REV2_NEG = ~REV2_MAG + 16'd1;

    logic [2:0]       state;
    logic [CMD_W-1:0] shift;
    logic             last_veer_right;
    logic [TMR_W-1:0] tmr;
    logic [BZ_W-1:0]  buzz_div;

    logic       bump;
    logic       in_bump;
    logic       dbnc_done;
    logic [1:0] code;

    assign bump      = !BMPL_n || !BMPR_n;
    assign in_bump   = (state == BUMP) || (state == DBNC);
    assign dbnc_done = (state == DBNC) && !bump && (tmr == DBNC_LAST);
    assign code      = shift[1:0];

    // Sequencer: step decode, phase timing, bump override and handshake pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            shift           <= '0;
            steps_left      <= '0;
            last_veer_right <= 1'b0;
            tmr             <= '0;
            clr_cmd_rdy     <= 1'b0;
            cmd_done        <= 1'b0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            cmd_done    <= 1'b0;
            if (bump && (state != IDLE)) begin
                state <= BUMP;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_rdy && line_present) begin
                            clr_cmd_rdy <= 1'b1;
                            shift       <= cmd;
                            steps_left  <= SL_FULL;
                            state       <= FOLLOW;
                        end
                    end
                    FOLLOW: begin
                        if (!line_present) begin
                            if ((steps_left == '0) || (code == CODE_STOP)) begin
                                state    <= IDLE;
                                cmd_done <= 1'b1;
                            end else if (code == CODE_UTURN) begin
                                state <= REV1;
                                tmr   <= '0;
                            end else begin
                                state           <= VEER;
                                last_veer_right <= (code == CODE_RIGHT);
                            end
                        end
                    end
                    VEER, REACQ: begin
                        if (line_present) begin
                            shift      <= shift >> 2;
                            steps_left <= steps_left - SL_ONE;
                            state      <= FOLLOW;
                        end
                    end
                    REV1: begin
                        if (tmr == REV1_LAST) begin
                            state <= REV2;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + TMR_ONE;
                        end
                    end
                    REV2: begin
                        if (tmr == REV2_LAST) begin
                            state <= REACQ;
                        end else begin
                            tmr <= tmr + TMR_ONE;
                        end
                    end
                    BUMP: begin
                        state <= DBNC;
                        tmr   <= '0;
                    end
                    DBNC: begin
                        if (tmr == DBNC_LAST) begin
                            state <= FOLLOW;
                        end else begin
                            tmr <= tmr + TMR_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Buzzer tone: held quiet outside the bump states, so every fresh bump starts a full half-period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz     <= 1'b0;
            buzz_div <= '0;
        end else if (!in_bump || dbnc_done) begin
            buzz     <= 1'b0;
            buzz_div <= '0;
        end else if (buzz_div == BZ_LAST) begin
            buzz     <= ~buzz;
            buzz_div <= '0;
        end else begin
            buzz_div <= buzz_div + BZ_ONE;
        end
    end

    // Motion outputs decoded from the registered state
    always_comb begin
        go         = 1'b0;
        err_opn_lp = 16'h0000;
        case (state)
            FOLLOW, REACQ: begin
                go = 1'b1;
            end
            VEER: begin
                go         = 1'b1;
                err_opn_lp = last_veer_right ? VEER_MAG : VEER_NEG;
            end
            REV1: begin
                go         = 1'b1;
                err_opn_lp = last_veer_right ? REV1_NEG : REV1_MAG;
            end
            REV2: begin
                go         = 1'b1;
                err_opn_lp = last_veer_right ? REV2_MAG : REV2_NEG;
            end
            default: begin
                go         = 1'b0;
                err_opn_lp = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_cmd_seq_proc.sv
// tb_cmd_seq_proc: directed scenarios followed by randomized traffic for
// cmd_seq_proc, compared every cycle against a behavioural model that keeps
// the pending steps in a queue and times phases with countdowns.

module tb_cmd_seq_proc;

    localparam int CMD_W     = 8;
    localparam int N_STEPS   = CMD_W / 2;
    localparam int REV1_CYC  = 8;
    localparam int REV2_CYC  = 12;
    localparam int DBNC_CYC  = 5;
    localparam int BUZZ_HALF = 3;

    // Model modes
    localparam int MD_IDLE   = 0;
    localparam int MD_FOLLOW = 1;
    localparam int MD_VEER   = 2;
    localparam int MD_REV1   = 3;
    localparam int MD_REV2   = 4;
    localparam int MD_REACQ  = 5;
    localparam int MD_BUMP   = 6;
    localparam int MD_DBNC   = 7;

    logic             clk;
    logic             rst_n;
    logic [CMD_W-1:0] cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             line_present;
    logic             BMPL_n;
    logic             BMPR_n;
    logic             go;
    logic [15:0]      err_opn_lp;
    logic             buzz;
    logic [2:0]       steps_left;
    logic             cmd_done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mMode;
    int mQ[$];
    bit mLastRight;
    int mRemain;
    int mBuzzN;
    bit mClr;
    bit mDone;

    cmd_seq_proc #(
        .CMD_W    (CMD_W),
        .REV1_CYC (REV1_CYC),
        .REV2_CYC (REV2_CYC),
        .DBNC_CYC (DBNC_CYC),
        .BUZZ_HALF(BUZZ_HALF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .line_present(line_present),
        .BMPL_n      (BMPL_n),
        .BMPR_n      (BMPR_n),
        .go          (go),
        .err_opn_lp  (err_opn_lp),
        .buzz        (buzz),
        .steps_left  (steps_left),
        .cmd_done    (cmd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mMode      = MD_IDLE;
        mQ.delete();
        mLastRight = 1'b0;
        mRemain    = 0;
        mBuzzN     = 0;
        mClr       = 1'b0;
        mDone      = 1'b0;
    endtask

    // One clock edge of the intended behaviour, using the inputs the bench is driving
    task automatic modelStep();
        bit bump;
        int c;
        bump  = !BMPL_n || !BMPR_n;
        c     = int'(cmd);
        mClr  = 1'b0;
        mDone = 1'b0;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (mMode != MD_IDLE && bump) begin
            if (mMode == MD_BUMP || mMode == MD_DBNC) mBuzzN++;
            else mBuzzN = 0;
            mMode = MD_BUMP;
            return;
        end
        case (mMode)
            MD_IDLE: begin
                if (cmd_rdy && line_present) begin
                    mQ.delete();
                    for (int k = 0; k < N_STEPS; k++) mQ.push_back((c >> (2 * k)) % 4);
                    mClr  = 1'b1;
                    mMode = MD_FOLLOW;
                end
            end
            MD_FOLLOW: begin
                if (!line_present) begin
                    if (mQ.size() == 0 || mQ[0] == 0) begin
                        mMode = MD_IDLE;
                        mDone = 1'b1;
                    end else if (mQ[0] == 3) begin
                        mMode   = MD_REV1;
                        mRemain = REV1_CYC;
                    end else begin
                        mMode      = MD_VEER;
                        mLastRight = (mQ[0] == 1);
                    end
                end
            end
            MD_VEER, MD_REACQ: begin
                if (line_present) begin
                    void'(mQ.pop_front());
                    mMode = MD_FOLLOW;
                end
            end
            MD_REV1: begin
                mRemain--;
                if (mRemain == 0) begin
                    mMode   = MD_REV2;
                    mRemain = REV2_CYC;
                end
            end
            MD_REV2: begin
                mRemain--;
                if (mRemain == 0) mMode = MD_REACQ;
            end
            MD_BUMP: begin
                mBuzzN++;
                mMode   = MD_DBNC;
                mRemain = DBNC_CYC;
            end
            MD_DBNC: begin
                mRemain--;
                if (mRemain == 0) mMode = MD_FOLLOW;
                else mBuzzN++;
            end
            default: mMode = MD_IDLE;
        endcase
    endtask

    function automatic logic [15:0] expErr();
        case (mMode)
            MD_VEER: return mLastRight ? 16'h0340 : 16'hFCC0;
            MD_REV1: return mLastRight ? 16'hFE20 : 16'h01E0;
            MD_REV2: return mLastRight ? 16'h0380 : 16'hFC80;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic expGo();
        return (mMode == MD_FOLLOW) || (mMode == MD_VEER) || (mMode == MD_REV1) ||
               (mMode == MD_REV2) || (mMode == MD_REACQ);
    endfunction

    function automatic logic expBuzz();
        if (mMode == MD_BUMP || mMode == MD_DBNC) return ((mBuzzN / BUZZ_HALF) % 2) == 1;
        return 1'b0;
    endfunction

    // Compare every output against the model
    task automatic checkOutput(input string tag);
        checkValue({tag, ".go"},         32'(go),          32'(expGo()));
        checkValue({tag, ".err"},        32'(err_opn_lp),  32'(expErr()));
        checkValue({tag, ".buzz"},       32'(buzz),        32'(expBuzz()));
        checkValue({tag, ".steps_left"}, 32'(steps_left),  32'(mQ.size()));
        checkValue({tag, ".clr_cmd_rdy"},32'(clr_cmd_rdy), 32'(mClr));
        checkValue({tag, ".cmd_done"},   32'(cmd_done),    32'(mDone));
    endtask

    // Drive one cycle of inputs, advance the clock and check against the model
    task automatic applyStimulus(input logic rdy, input logic [CMD_W-1:0] c, input logic lp,
                                 input logic bl, input logic br);
        cmd_rdy      = rdy;
        cmd          = c;
        line_present = lp;
        BMPL_n       = bl;
        BMPR_n       = br;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("cycle");
    endtask

    initial begin
        logic rRdy;
        logic [CMD_W-1:0] rCmd;
        logic rLp;
        int bumpLeft;
        int bumpSel;
        logic bl;
        logic br;

        rst_n = 1'b0;
        cmd = '0; cmd_rdy = 1'b0; line_present = 1'b0; BMPL_n = 1'b1; BMPR_n = 1'b1;
        modelReset();
        applyStimulus(0, 8'h00, 0, 1, 1);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("reset.go",    32'(go),         32'd0);
        checkValue("reset.err",   32'(err_opn_lp), 32'd0);
        checkValue("reset.buzz",  32'(buzz),       32'd0);
        checkValue("reset.steps", 32'(steps_left), 32'd0);
        rst_n = 1'b1;

        // Capture and guard against re-capture while busy
        applyStimulus(1, 8'h09, 1, 1, 1);
        checkValue("capture.clr",   32'(clr_cmd_rdy), 32'd1);
        checkValue("capture.go",    32'(go),          32'd1);
        checkValue("capture.steps", 32'(steps_left),  32'd4);
        applyStimulus(0, 8'h09, 1, 1, 1);
        checkValue("capture.clr_pulse", 32'(clr_cmd_rdy), 32'd0);
        applyStimulus(1, 8'hFF, 1, 1, 1);
        applyStimulus(1, 8'hFF, 1, 1, 1);
        checkValue("guard.no_ack", 32'(clr_cmd_rdy), 32'd0);
        applyStimulus(0, 8'hFF, 1, 1, 1);

        // Veer right, veer left, then stop
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("veer.right", 32'(err_opn_lp), 32'h0340);
        applyStimulus(0, 8'h00, 1, 1, 1);
        checkValue("veer.steps3", 32'(steps_left), 32'd3);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("veer.left", 32'(err_opn_lp), 32'hFCC0);
        applyStimulus(0, 8'h00, 1, 1, 1);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("veer.done", 32'(cmd_done), 32'd1);
        checkValue("veer.idle_go", 32'(go), 32'd0);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("veer.done_pulse", 32'(cmd_done), 32'd0);

        // U-turn after a right veer
        applyStimulus(1, 8'h0D, 1, 1, 1);
        applyStimulus(0, 8'h0D, 1, 1, 1);
        applyStimulus(0, 8'h00, 0, 1, 1);
        applyStimulus(0, 8'h00, 1, 1, 1);
        for (int i = 0; i < REV1_CYC; i++) begin
            applyStimulus(0, 8'h00, 0, 1, 1);
            checkValue("uturn.rev1", 32'(err_opn_lp), 32'hFE20);
        end
        for (int i = 0; i < REV2_CYC; i++) begin
            applyStimulus(0, 8'h00, 0, 1, 1);
            checkValue("uturn.rev2", 32'(err_opn_lp), 32'h0380);
        end
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("uturn.reacq_err", 32'(err_opn_lp), 32'h0000);
        checkValue("uturn.reacq_go",  32'(go),         32'd1);
        applyStimulus(0, 8'h00, 1, 1, 1);
        checkValue("uturn.steps2", 32'(steps_left), 32'd2);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("uturn.done", 32'(cmd_done), 32'd1);

        // Bump mid-veer, debounce with a re-bump, then the step re-decodes
        applyStimulus(1, 8'h09, 1, 1, 1);
        applyStimulus(0, 8'h09, 1, 1, 1);
        applyStimulus(0, 8'h00, 0, 1, 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 8'h00, 0, 0, 1);
            checkValue("bump.go",   32'(go),   32'd0);
            checkValue("bump.buzz", 32'(buzz), 32'((k / 3) % 2));
        end
        for (int k = 0; k < 3; k++) applyStimulus(0, 8'h00, 0, 1, 1);
        applyStimulus(0, 8'h00, 0, 1, 0);
        for (int k = 0; k < DBNC_CYC; k++) begin
            applyStimulus(0, 8'h00, 0, 1, 1);
            checkValue("dbnc.hold", 32'(go), 32'd0);
        end
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("dbnc.resume", 32'(go), 32'd1);
        checkValue("dbnc.buzz_off", 32'(buzz), 32'd0);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("dbnc.redecode", 32'(err_opn_lp), 32'h0340);
        applyStimulus(0, 8'h00, 1, 1, 1);

        // Exhaustion of an all-veer command
        rst_n = 1'b0;
        modelReset();
        applyStimulus(0, 8'h00, 1, 1, 1);
        rst_n = 1'b1;
        applyStimulus(1, 8'h55, 1, 1, 1);
        applyStimulus(0, 8'h55, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 8'h00, 0, 1, 1);
            applyStimulus(0, 8'h00, 1, 1, 1);
        end
        checkValue("exhaust.steps0", 32'(steps_left), 32'd0);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("exhaust.done", 32'(cmd_done), 32'd1);
        checkValue("exhaust.go",   32'(go),       32'd0);

        // Reset in the middle of the second U-turn phase
        applyStimulus(1, 8'h0D, 1, 1, 1);
        applyStimulus(0, 8'h0D, 1, 1, 1);
        applyStimulus(0, 8'h00, 0, 1, 1);
        applyStimulus(0, 8'h00, 1, 1, 1);
        for (int k = 0; k < REV1_CYC + 3; k++) applyStimulus(0, 8'h00, 0, 1, 1);
        checkValue("midrev2.err", 32'(err_opn_lp), 32'h0380);
        cmd_rdy = 1'b1; cmd = 8'h55; line_present = 1'b1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkValue("rst.go",    32'(go),         32'd0);
        checkValue("rst.err",   32'(err_opn_lp), 32'd0);
        checkValue("rst.steps", 32'(steps_left), 32'd0);
        applyStimulus(1, 8'h55, 1, 1, 1);
        rst_n = 1'b1;
        applyStimulus(1, 8'h55, 1, 1, 1);
        checkValue("rst.reack", 32'(clr_cmd_rdy), 32'd1);
        applyStimulus(0, 8'h55, 1, 1, 1);

        // Randomized traffic with a UART-like pending command and random bumps
        rRdy = 1'b0; rCmd = '0; rLp = 1'b1; bumpLeft = 0; bumpSel = 0;
        for (int i = 0; i < 2000; i++) begin
            if (mClr) rRdy = 1'b0;
            else if (!rRdy && $urandom_range(0, 7) == 0) begin
                rRdy = 1'b1;
                rCmd = CMD_W'($urandom);
            end
            if ($urandom_range(0, 4) == 0) rLp = !rLp;
            if (bumpLeft > 0) bumpLeft--;
            else if ($urandom_range(0, 49) == 0) begin
                bumpLeft = $urandom_range(1, 12);
                bumpSel  = $urandom_range(0, 2);
            end
            bl = !(bumpLeft > 0 && bumpSel != 1);
            br = !(bumpLeft > 0 && bumpSel != 0);
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            applyStimulus(rRdy, rCmd, rLp, bl, br);
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_seq_proc.md
# cmd_seq_proc

Parametrised command sequencer for the line-following robot: accepts a packed command word from the UART wrapper and consumes CMD_W/2 two-bit steps, one per line-loss event. Drives go, the steering override err_opn_lp and the buzzer to the motion controller. Over the single-fixed-word processor it adds configurable word width and timings, a step counter with completion pulse, a tone-generating buzzer and bump debounce on release.

## Interface
- CMD_W, 16: command width; even, ≥2; N_STEPS = CMD_W/2.
- VEER_MAG, 16'h340: veer override magnitude.
- REV1_MAG, 16'h1E0: U-turn phase-1 magnitude.
- REV2_MAG, 16'h380: U-turn phase-2 magnitude.
- REV1_CYC, 1441792: phase-1 duration in clocks.
- REV2_CYC, 65011712: phase-2 duration in clocks.
- DBNC_CYC, 4194304: bumper-release debounce in clocks.
- BUZZ_HALF, 25000: buzz half-period in clocks.
- TMR_W, 27: timer width; must hold the largest *_CYC.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd  in  CMD_W  command word from UART wrapper.
- cmd_rdy  in  1  command valid.
- clr_cmd_rdy  out  1  one-cycle capture acknowledge.
- line_present  in  1  line sensor.
- BMPL_n, BMPR_n  in  1 each  bumpers, active-low.
- go  out  1  motion enable.
- err_opn_lp  out  16  signed steering override.
- buzz  out  1  buzzer drive.
- steps_left  out  $clog2(N_STEPS+1)  steps remaining.
- cmd_done  out  1  one-cycle pulse on sequence completion.

## Operation
- Reset: state IDLE; go, buzz, clr_cmd_rdy, cmd_done = 0; err_opn_lp = 0; steps_left, shift register, last_veer_right, timer, buzz divider = 0.
- Step code = shift[1:0]: 00 stop, 01 veer right (+VEER_MAG, last_veer_right←1), 10 veer left (−VEER_MAG, last_veer_right←0), 11 U-turn.
- IDLE: go=0, err=0, bumpers ignored. cmd_rdy && line_present → clr_cmd_rdy=1 this cycle, shift←cmd, steps_left←N_STEPS, → FOLLOW. cmd_rdy without line_present: wait, no ack.
- FOLLOW: go=1, err=0. On !line_present: steps_left==0 or code 00 → IDLE with cmd_done pulse; 01/10 → VEER; 11 → REV1, timer cleared.
- VEER: go=1, err=±VEER_MAG. On line_present: shift right by 2 (zero fill), steps_left−1, → FOLLOW.
- REV1: go=1, err = last_veer_right ? −REV1_MAG : +REV1_MAG for REV1_CYC cycles, then → REV2, timer cleared.
- REV2: go=1, err = last_veer_right ? +REV2_MAG : −REV2_MAG for REV2_CYC cycles, then → REACQ.
- REACQ: go=1, err=0. On line_present: shift by 2, steps_left−1, → FOLLOW.
- Bump: in any state except IDLE, either bumper low → BUMP (priority over every other transition). BUMP: go=0, err=0, buzz toggles every BUZZ_HALF cycles. Both released → DBNC, timer cleared. DBNC: go=0, buzz keeps toggling; any bumper low → BUMP; DBNC_CYC released cycles → FOLLOW, buzz←0. An interrupted step is not consumed, so it re-decodes on the next line loss.
- cmd_rdy outside IDLE: ignored and not acknowledged, stays pending.
- Negative magnitudes are 16-bit two's complement.

## Timing
- go, err_opn_lp and steps_left are decoded from registered state and change in the cycle the new state is entered. clr_cmd_rdy and cmd_done are single-cycle pulses.
- The timer clears on phase entry. A phase expires at tmr == CYC−1, so it lasts exactly CYC cycles.
- Buzz divider clears on BUMP entry from a non-bump state. The first toggle occurs BUZZ_HALF cycles after entry.
- Bump and line_present change in the same cycle: bump wins.
- Reset mid-operation: immediate return to reset values; pending cmd_rdy is re-acked after reset.

## Test plan
Overrides for all scenarios: CMD_W=8, REV1_CYC=8, REV2_CYC=12, DBNC_CYC=5, BUZZ_HALF=3.
- Capture: cmd=8'h09, cmd_rdy=1, line_present=1 → clr_cmd_rdy one cycle, go=1, steps_left=4.
- Veer sequence: cmd=8'h09; drop and restore line three times → err +0x340, then −0x340, then at the third loss (code 00) IDLE, cmd_done pulse, go=0.
- U-turn after right veer: cmd=8'h0D → after the 01 step, line loss gives err=0xFE20 for 8 cycles, 0x0380 for 12 cycles, then 0 with go=1 until line_present.
- Bump: pull BMPL_n low for 10 cycles mid-VEER → go=0, buzz toggles every 3 cycles. Release → FOLLOW after 5 cycles. A re-bump at cycle 3 of debounce restarts the 5-cycle count.
- Exhaustion: cmd=8'h55, four veers → steps_left=0. Next loss → IDLE, cmd_done pulse.
- Guards: cmd_rdy in FOLLOW → no clr_cmd_rdy. Assert rst_n mid-REV2 → all outputs 0 next edge.
